// File: rtl/t04_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Imported by the arbiter top and its transaction timer.
package t04_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_BUS,
    D_BUS,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } arb_op_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/t04_arb_timer.sv
// Per-transaction cycle counter. It counts up while enabled and flags
// the final allowed bus cycle of a transaction.
module t04_arb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the last cycle the strobe may stay up.
  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/t04_mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one bus port.
// Grants are latched, completions return one-cycle acks with registered data.
module t04_mem_arbiter
  import t04_mem_arb_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [DATA_W-1:0] bus_dat_o,
  output logic [3:0]        bus_sel,
  input  logic [DATA_W-1:0] bus_dat_i,
  input  logic              bus_ack,
  output logic              i_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] memload,
  output logic              timeout_err
);

  arb_state_t        state_q, state_d;
  arb_op_t           op_q, op_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_adr_q, bus_adr_d;
  logic [DATA_W-1:0] bus_dat_o_q, bus_dat_o_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic [DATA_W-1:0] memload_q, memload_d;
  logic              timeout_err_q, timeout_err_d;

  logic in_bus;
  logic timer_expired;

  assign in_bus = (state_q == I_BUS) || (state_q == D_BUS);

  t04_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    bus_read_d    = 1'b0;
    bus_write_d   = 1'b0;
    bus_adr_d     = bus_adr_q;
    bus_dat_o_d   = bus_dat_o_q;
    bus_sel_d     = bus_sel_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    instruction_d = instruction_q;
    memload_d     = memload_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        // Data beats fetch; store beats load.
        if (d_write) begin
          state_d     = D_BUS;
          op_d        = OP_STORE;
          bus_write_d = 1'b1;
          bus_adr_d   = d_addr;
          bus_dat_o_d = d_wdata;
          bus_sel_d   = d_sel;
        end else if (d_read) begin
          state_d     = D_BUS;
          op_d        = OP_LOAD;
          bus_read_d  = 1'b1;
          bus_adr_d   = d_addr;
          bus_dat_o_d = '0;
          bus_sel_d   = 4'hF;
        end else if (i_req) begin
          state_d     = I_BUS;
          op_d        = OP_FETCH;
          bus_read_d  = 1'b1;
          bus_adr_d   = i_addr;
          bus_dat_o_d = '0;
          bus_sel_d   = 4'hF;
        end
      end

      I_BUS, D_BUS: begin
        if (bus_ack) begin
          state_d = RESP;
          if (op_q == OP_FETCH) begin
            instruction_d = bus_dat_i;
            i_ack_d       = 1'b1;
          end else begin
            if (op_q == OP_LOAD) begin
              memload_d = bus_dat_i;
            end
            d_ack_d = 1'b1;
          end
        end else if (timer_expired) begin
          // Forced completion: reads return zero, the error flag sticks.
          state_d       = RESP;
          timeout_err_d = 1'b1;
          if (op_q == OP_FETCH) begin
            instruction_d = '0;
            i_ack_d       = 1'b1;
          end else begin
            if (op_q == OP_LOAD) begin
              memload_d = '0;
            end
            d_ack_d = 1'b1;
          end
        end else begin
          bus_read_d  = bus_read_q;
          bus_write_d = bus_write_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= OP_FETCH;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_adr_q     <= '0;
      bus_dat_o_q   <= '0;
      bus_sel_q     <= 4'h0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      instruction_q <= '0;
      memload_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_adr_q     <= bus_adr_d;
      bus_dat_o_q   <= bus_dat_o_d;
      bus_sel_q     <= bus_sel_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      instruction_q <= instruction_d;
      memload_q     <= memload_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_adr     = bus_adr_q;
  assign bus_dat_o   = bus_dat_o_q;
  assign bus_sel     = bus_sel_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign instruction = instruction_q;
  assign memload     = memload_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/t04_mem_arbiter.md
# t04_mem_arbiter

Single-port memory arbiter between the datapath's instruction-fetch requester and its data load/store requester. It serialises both onto one shared bus-manager port, returns `i_ack`/`d_ack` pulses with registered `instruction`/`memload` data to the request unit, and enforces a per-transaction timeout. It sits between the datapath request unit and the bus manager.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum bus cycles per transaction before forced completion (≥2)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low (asserted when 0)
- `i_req`  in  1  instruction fetch request, level, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `d_read`  in  1  data load request, level
- `d_write`  in  1  data store request, level
- `d_addr`  in  ADDR_W  load/store address
- `d_wdata`  in  DATA_W  store data
- `d_sel`  in  4  store byte enables
- `bus_read`  out  1  bus read strobe
- `bus_write`  out  1  bus write strobe
- `bus_adr`  out  ADDR_W  bus address
- `bus_dat_o`  out  DATA_W  bus write data
- `bus_sel`  out  4  bus byte enables (4'hF on reads)
- `bus_dat_i`  in  DATA_W  bus read data, valid with `bus_ack`
- `bus_ack`  in  1  one-cycle bus completion pulse
- `i_ack`  out  1  one-cycle fetch completion pulse
- `d_ack`  out  1  one-cycle data completion pulse
- `instruction`  out  DATA_W  registered fetched word
- `memload`  out  DATA_W  registered loaded word
- `timeout_err`  out  1  sticky timeout flag

## Operation
- States: IDLE, I_BUS, D_BUS, RESP.
- IDLE: if `d_write` → D_BUS (write); else if `d_read` → D_BUS (read); else if `i_req` → I_BUS; else stay. Data requests beat fetch. Write beats read if both asserted.
- On grant: `bus_adr`, `bus_dat_o`, `bus_sel`, and the op are registered from the winning requester. Later changes on requester inputs are ignored until RESP.
- I_BUS/D_BUS: the matching strobe is held high every cycle until `bus_ack`. The timer counts up from 0 each cycle in the state.
- `bus_ack` in I_BUS: `instruction` ← `bus_dat_i`, go RESP with `i_ack`.
- `bus_ack` in D_BUS read: `memload` ← `bus_dat_i`, go RESP with `d_ack`.
- `bus_ack` in D_BUS write: go RESP with `d_ack`; `memload` unchanged.
- Timer reaching TIMEOUT−1 without `bus_ack`: drop the strobe, set `timeout_err`, load 0 into the data register for reads, go RESP with the matching ack.
- RESP: lasts exactly one cycle with the ack high. Requests are ignored. Always → IDLE. Requesters must drop or change their request in the cycle after the ack.
- `bus_ack` outside I_BUS/D_BUS is ignored.
- Reset (`rst`=0 at an edge, any state, including mid-transaction): state IDLE, timer 0, all strobes/acks 0, `bus_adr`/`bus_dat_o`/`instruction`/`memload` 0, `bus_sel` 0, `timeout_err` 0. An abandoned bus transaction is not completed.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge N → strobe high from cycle N+1.
- `bus_ack` at edge M → requester ack and data valid in cycle M+1 (RESP) → IDLE at M+2.
- Minimum turnaround: 3 cycles from grant to ack when `bus_ack` arrives in the first strobe cycle.
- A new grant is possible at earliest 1 cycle after RESP, i.e. one IDLE cycle between transactions.
- Fetch pending during a data transaction is served next, unless another data request is already present in IDLE.
- Timeout: the strobe is held for exactly TIMEOUT cycles, then RESP.

## Structure
- Package `t04_mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, I_BUS, D_BUS, RESP);
  - the `arb_op_t` enum (OP_FETCH, OP_LOAD, OP_STORE);
  - the default TIMEOUT constant.
- One sub-module, `t04_arb_timer`: clear/enable inputs, `expired` output; width `$clog2(TIMEOUT+1)`.

## Test plan
- Fetch alone: `i_req`, `i_addr`=0x100, `bus_ack` with 0x00500093 two cycles after the strobe → `bus_read` with `bus_adr`=0x100; `i_ack` one cycle with `instruction`=0x00500093; `d_ack` stays 0.
- Contention: `i_req` and `d_read` together in IDLE → data served first, then fetch; `d_ack` precedes `i_ack`; exactly one strobe is high at any cycle.
- Store: `d_write`, `d_addr`=0x2000, `d_wdata`=0xCAFEF00D, `d_sel`=4'b0011 → bus signals match these values; `d_ack` one cycle; `memload` unchanged.
- Timeout: TIMEOUT=8, load with `bus_ack` never asserted → strobe high 8 cycles, then `d_ack` with `memload`=0 and `timeout_err`=1 sticky until reset.
- Reset mid-transaction: `rst`=0 during D_BUS → next cycle all outputs 0 and state IDLE; after release, a fetch completes normally.
- Held request: `i_req` kept high one cycle past `i_ack` (during RESP) → no second grant for that cycle; regrant only from the following IDLE if still asserted.
